// File: rtl/draw_pkg.sv
// Shared definitions for the symbol-draw path: scheduler state encoding, symbol id type
// and the screen limits also used by the drawer and the VGA glue.
package draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    typedef logic [1:0] sym_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin choice; last = index of the requester granted last.
// On a tie the requester that was not granted last wins. Grant is one-hot or zero.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares one symbol drawer between two cell-addressed requesters: round-robin pick,
// cell-to-pixel conversion, one-cycle launch, completion wait with watchdog abort.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int X0      = 16,
    parameter int Y0      = 8,
    parameter int CELL_W  = 16,
    parameter int CELL_H  = 16,
    parameter int COLS    = 8,
    parameter int ROWS    = 6,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [2:0] req_col0,
    input  logic [2:0] req_col1,
    input  logic [2:0] req_row0,
    input  logic [2:0] req_row1,
    input  logic [1:0] req_sym0,
    input  logic [1:0] req_sym1,
    output logic [1:0] ack,
    output logic       err,
    output logic       draw_start,
    output logic [7:0] draw_x,
    output logic [6:0] draw_y,
    output logic [1:0] draw_sym,
    input  logic       draw_done,
    output logic       busy
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [1:0]        ack_q, ack_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    sym_t              sym_q, sym_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              last_q, last_d;

    logic [1:0] req_eff;
    logic [1:0] gnt;
    logic       win;
    logic [2:0] col_w;
    logic [2:0] row_w;
    sym_t       sym_w;
    logic       out_of_range;

    // A requester sees its ack one cycle late and may still be holding req; don't grant it twice.
    assign req_eff = req & ~ack_q;

    rr_arbiter2 u_arb (
        .req  (req_eff),
        .last (last_q),
        .gnt  (gnt)
    );

    assign win          = gnt[1];
    assign col_w        = win ? req_col1 : req_col0;
    assign row_w        = win ? req_row1 : req_row0;
    assign sym_w        = win ? req_sym1 : req_sym0;
    assign out_of_range = (32'(col_w) >= COLS) || (32'(row_w) >= ROWS);

    always_comb begin
        state_d = state_q;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        start_d = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        sym_d   = sym_q;
        wdog_d  = wdog_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    ack_d  = gnt;
                    last_d = win;
                    if (out_of_range) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LAUNCH;
                        x_d     = 8'(9'(X0) + 9'(col_w) * 9'(CELL_W));
                        y_d     = 7'(8'(Y0) + 8'(row_w) * 8'(CELL_H));
                        sym_d   = sym_w;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                start_d = 1'b1;
                wdog_d  = '0;
            end
            ST_WAIT: begin
                // Completion takes priority over a watchdog expiry on the same cycle.
                if (draw_done) begin
                    state_d = ST_IDLE;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sym_q   <= '0;
            wdog_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sym_q   <= sym_d;
            wdog_q  <= wdog_d;
            last_q  <= last_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign draw_start = start_q;
    assign busy       = busy_q;
    assign draw_x     = x_q;
    assign draw_y     = y_q;
    assign draw_sym   = sym_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: default-parameter instance plus a TIMEOUT=20 instance sharing
// the same stimulus; expected grants queued at request time and checked as acks appear.
module tb_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [2:0] req_col0, req_col1, req_row0, req_row1;
    logic [1:0] req_sym0, req_sym1;
    logic       draw_done;

    logic [1:0] ack,   ack_t;
    logic       err,   err_t;
    logic       draw_start, draw_start_t;
    logic [7:0] draw_x, draw_x_t;
    logic [6:0] draw_y, draw_y_t;
    logic [1:0] draw_sym, draw_sym_t;
    logic       busy, busy_t;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] ack;
        logic       err;
        logic [7:0] x;
        logic [6:0] y;
        logic [1:0] sym;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    draw_scheduler dut (
        .clk(clk), .reset(reset), .req(req),
        .req_col0(req_col0), .req_col1(req_col1),
        .req_row0(req_row0), .req_row1(req_row1),
        .req_sym0(req_sym0), .req_sym1(req_sym1),
        .ack(ack), .err(err), .draw_start(draw_start),
        .draw_x(draw_x), .draw_y(draw_y), .draw_sym(draw_sym),
        .draw_done(draw_done), .busy(busy)
    );

    draw_scheduler #(.TIMEOUT(20)) dut_t (
        .clk(clk), .reset(reset), .req(req),
        .req_col0(req_col0), .req_col1(req_col1),
        .req_row0(req_row0), .req_row1(req_row1),
        .req_sym0(req_sym0), .req_sym1(req_sym1),
        .ack(ack_t), .err(err_t), .draw_start(draw_start_t),
        .draw_x(draw_x_t), .draw_y(draw_y_t), .draw_sym(draw_sym_t),
        .draw_done(draw_done), .busy(busy_t)
    );

    // Reference mapping with default geometry: X0=16, Y0=8, 16x16 cells, 8x6 grid.
    function automatic exp_t mk(logic [1:0] a, logic [2:0] col, logic [2:0] row, logic [1:0] sym);
        exp_t e;
        e.ack = a;
        e.err = (int'(col) >= 8) || (int'(row) >= 6);
        e.x   = 8'(16 + int'(col) * 16);
        e.y   = 7'(8 + int'(row) * 16);
        e.sym = sym;
        return e;
    endfunction

    task automatic set_req0(logic [2:0] c, logic [2:0] r, logic [1:0] s);
        req_col0 = c; req_row0 = r; req_sym0 = s;
    endtask

    task automatic set_req1(logic [2:0] c, logic [2:0] r, logic [1:0] s);
        req_col1 = c; req_row1 = r; req_sym1 = s;
    endtask

    task automatic do_reset(input logic [1:0] r);
        req = r;
        draw_done = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(output logic [1:0] a, output bit ok);
        a = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                ok = 1'b1;
                return;
            end
        end
    endtask

    // One request from ack to completion; lat = cycles from draw_start to draw_done.
    task automatic serve(input int lat, input bit drop, input string tag);
        logic [1:0] a;
        bit ok;
        exp_t e;
        wait_ack(a, ok);
        n_tests++;
        if (!ok || sbq.size() == 0) begin
            n_fail++;
            $display("FAIL %s ack: timed out or unexpected (ok=%0d, queued=%0d)", tag, ok, sbq.size());
            return;
        end
        e = sbq.pop_front();
        if (a !== e.ack || err !== e.err) begin
            n_fail++;
            $display("FAIL %s ack: got ack=%b err=%b, expected ack=%b err=%b", tag, a, err, e.ack, e.err);
        end
        if (drop) req = req & ~a;
        @(negedge clk);
        n_tests++;
        if (e.err) begin
            if (draw_start !== 1'b0 || busy !== 1'b0 || ack !== 2'b00) begin
                n_fail++;
                $display("FAIL %s reject: got start=%b busy=%b ack=%b, expected 0 0 00",
                         tag, draw_start, busy, ack);
            end
            return;
        end
        if (draw_start !== 1'b1 || ack !== 2'b00 || draw_x !== e.x || draw_y !== e.y || draw_sym !== e.sym) begin
            n_fail++;
            $display("FAIL %s launch: got start=%b ack=%b x=%0d y=%0d sym=%0d, expected 1 00 %0d %0d %0d",
                     tag, draw_start, ack, draw_x, draw_y, draw_sym, e.x, e.y, e.sym);
        end
        repeat (lat - 1) @(negedge clk);
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || draw_x !== e.x || draw_y !== e.y) begin
            n_fail++;
            $display("FAIL %s done: got busy=%b x=%0d y=%0d, expected 0 %0d %0d",
                     tag, busy, draw_x, draw_y, e.x, e.y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b11;
        draw_done = 1'b0;
        set_req0(3'd1, 3'd1, 2'd1);
        set_req1(3'd2, 3'd2, 2'd2);
        repeat (3) @(negedge clk);
        n_tests++;
        if (ack !== 2'b00 || err !== 1'b0 || draw_start !== 1'b0 || busy !== 1'b0 ||
            draw_x !== 8'd0 || draw_y !== 7'd0 || draw_sym !== 2'd0 || busy_t !== 1'b0 || ack_t !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got ack=%b err=%b start=%b busy=%b x=%0d y=%0d sym=%0d, expected all 0",
                     ack, err, draw_start, busy, draw_x, draw_y, draw_sym);
        end
        req = 2'b00;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset(2'b00);
        set_req0(3'd2, 3'd1, 2'd3);
        req = 2'b01;
        sbq.push_back(mk(2'b01, 3'd2, 3'd1, 2'd3));
        serve(52, 1'b1, "single");
    endtask

    task automatic test_back_to_back();
        do_reset(2'b11);
        set_req0(3'd0, 3'd0, 2'd0);
        set_req1(3'd3, 3'd4, 2'd1);
        sbq.push_back(mk(2'b01, 3'd0, 3'd0, 2'd0));
        sbq.push_back(mk(2'b10, 3'd3, 3'd4, 2'd1));
        sbq.push_back(mk(2'b01, 3'd0, 3'd0, 2'd0));
        sbq.push_back(mk(2'b10, 3'd3, 3'd4, 2'd1));
        for (int i = 0; i < 4; i++) serve(10, 1'b0, "alternate");
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_range();
        do_reset(2'b00);
        set_req1(3'd7, 3'd5, 2'd2);
        req = 2'b10;
        sbq.push_back(mk(2'b10, 3'd7, 3'd5, 2'd2));
        serve(4, 1'b1, "max_cell");
        set_req0(3'd8 - 3'd0, 3'd0, 2'd1);
        req_col0 = 3'd0;
        req_col0 = req_col0 - 3'd0;
        // column 8 cannot be expressed on 3 bits; the reachable out-of-range cases are row 6/7
        set_req0(3'd1, 3'd6, 2'd1);
        req = 2'b01;
        sbq.push_back(mk(2'b01, 3'd1, 3'd6, 2'd1));
        serve(4, 1'b1, "bad_row");
        set_req1(3'd4, 3'd7, 2'd0);
        req = 2'b10;
        sbq.push_back(mk(2'b10, 3'd4, 3'd7, 2'd0));
        serve(4, 1'b1, "bad_row7");
        set_req0(3'd6, 3'd2, 2'd2);
        req = 2'b01;
        sbq.push_back(mk(2'b01, 3'd6, 3'd2, 2'd2));
        serve(7, 1'b1, "after_reject");
    endtask

    task automatic test_timeout();
        logic [1:0] a;
        bit ok;
        int first_err;
        do_reset(2'b00);
        set_req0(3'd0, 3'd0, 2'd1);
        req = 2'b01;
        wait_ack(a, ok);
        req = 2'b00;
        @(negedge clk);
        n_tests++;
        if (!ok || draw_start_t !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_launch: got ok=%0d start=%b, expected 1 1", ok, draw_start_t);
        end
        first_err = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (err_t === 1'b1 && first_err < 0) first_err = k;
        end
        n_tests++;
        if (first_err !== 20 || busy_t !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err: got err at cycle %0d busy=%b, expected cycle 20 busy=0", first_err, busy_t);
        end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy_t !== 1'b0 || busy !== 1'b0 || err_t !== 1'b0) begin
            n_fail++;
            $display("FAIL done_in_idle: got busy_t=%b busy=%b err_t=%b, expected 0 0 0", busy_t, busy, err_t);
        end
        set_req1(3'd5, 3'd3, 2'd3);
        req = 2'b10;
        wait_ack(a, ok);
        req = 2'b00;
        n_tests++;
        if (!ok || ack_t !== 2'b10 || err_t !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover_ack: got ack_t=%b err_t=%b, expected 10 0", ack_t, err_t);
        end
        @(negedge clk);
        n_tests++;
        if (draw_start_t !== 1'b1 || draw_x_t !== 8'd96 || draw_y_t !== 7'd56 || draw_sym_t !== 2'd3) begin
            n_fail++;
            $display("FAIL timeout_recover_launch: got start=%b x=%0d y=%0d sym=%0d, expected 1 96 56 3",
                     draw_start_t, draw_x_t, draw_y_t, draw_sym_t);
        end
    endtask

    task automatic test_coincide();
        logic [1:0] a;
        bit ok;
        bit saw_err;
        do_reset(2'b00);
        set_req0(3'd1, 3'd0, 2'd0);
        req = 2'b01;
        wait_ack(a, ok);
        req = 2'b00;
        @(negedge clk);
        saw_err = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (err_t !== 1'b0) saw_err = 1'b1;
        end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        if (err_t !== 1'b0) saw_err = 1'b1;
        n_tests++;
        if (!ok || saw_err || busy_t !== 1'b0) begin
            n_fail++;
            $display("FAIL done_vs_timeout: got err=%b busy_t=%b, expected err=0 busy_t=0", saw_err, busy_t);
        end
    endtask

    task automatic test_done_in_launch();
        logic [1:0] a;
        bit ok;
        do_reset(2'b00);
        set_req1(3'd2, 3'd2, 2'd1);
        req = 2'b10;
        wait_ack(a, ok);
        req = 2'b00;
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!ok || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_in_launch: got ok=%0d busy=%b, expected 1 1", ok, busy);
        end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_after_launch: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0] a;
        bit ok;
        do_reset(2'b00);
        set_req0(3'd3, 3'd2, 2'd2);
        req = 2'b01;
        wait_ack(a, ok);
        req = 2'b00;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || draw_x !== 8'd0 || draw_y !== 7'd0 || draw_sym !== 2'd0 ||
            ack !== 2'b00 || err !== 1'b0 || draw_start !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b x=%0d y=%0d sym=%0d, expected all 0",
                     busy, draw_x, draw_y, draw_sym);
        end
        set_req0(3'd1, 3'd1, 2'd1);
        set_req1(3'd2, 3'd2, 2'd2);
        req = 2'b11;
        sbq.push_back(mk(2'b01, 3'd1, 3'd1, 2'd1));
        sbq.push_back(mk(2'b10, 3'd2, 3'd2, 2'd2));
        @(negedge clk);
        reset = 1'b0;
        serve(5, 1'b1, "post_reset_first");
        serve(5, 1'b1, "post_reset_second");
    endtask

    initial begin
        req = 2'b00;
        req_col0 = '0; req_col1 = '0; req_row0 = '0; req_row1 = '0;
        req_sym0 = '0; req_sym1 = '0;
        draw_done = 1'b0;
        reset = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_range();
        test_timeout();
        test_coincide();
        test_done_in_launch();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
